pulse_sched: RTL and testbench
==============================

# pulse_sched

Round-robin scheduler that shares a single active-low one-shot pulse generator among `N_REQ` requesters. Each requester asks for a low pulse of its own programmable length on the shared `dout` line. The block arbitrates the requests, then times and drives the pulse. It signals completion back to the winner and enforces a minimum high gap between consecutive pulses. It sits between the control logic of several requesting units and the one physical strobe/enable line they share.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `LEN_W`, default 4: width of each length field; the maximum pulse length is 2^LEN_W-1 cycles.
- `GAP`, default 1: extra high cycles inserted after each pulse, before the next arbitration (0..15).

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  level request per requester. It must be held until the matching `done`.
- `len`  in  N_REQ*LEN_W  packed pulse lengths; requester i uses bits [i*LEN_W +: LEN_W].
- `dout`  out  1  shared pulse output. It is active-low and idles at 1.
- `gnt`  out  N_REQ  one-hot grant. It is high for exactly the cycles in which `dout` is low for that requester.
- `done`  out  N_REQ  one-cycle completion strobe to the granted requester.
- `busy`  out  1  high in PULSE and GAP states.

## Operation
- FSM has three states: IDLE, PULSE, GAP. Reset state is IDLE.
- Reset values: `dout`=1, `gnt`=0, `done`=0, `busy`=0, RR pointer=0, counter=0.
- **IDLE:**
  - If `req`≠0, select the first set bit searching upward from the pointer, wrapping at N_REQ-1→0.
  - Latch that requester's `len` as L. If `len`=0, L=1.
  - Go to PULSE with the counter loaded to 1.
  - Set the pointer to (winner+1) mod N_REQ.
  - If `req`=0, stay in IDLE and do not change the pointer.
- **PULSE:**
  - `dout`=0 and `gnt[winner]`=1.
  - The counter increments each cycle.
  - When counter==L, the next state is GAP if GAP>0, otherwise IDLE.
- **Exit from PULSE:**
  - In the first cycle after PULSE, `done[winner]`=1 for exactly one cycle.
  - In that same cycle, `dout`=1 and `gnt`=0.
- **GAP:** `dout`=1 and `busy`=1. The state lasts GAP cycles, then goes to IDLE.
- A pulse is never aborted by requests:
  - Deasserting `req[winner]` during PULSE does not shorten the pulse.
  - `done` still fires.
- `len` is sampled only in the IDLE arbitration cycle. Later changes to `len` are ignored for the pulse in progress.
- `req` held high after `done` counts as a new request. That requester competes again in the next IDLE cycle, at lowest priority relative to the pointer.
- Requests arriving during PULSE or GAP are not lost. Because `req` is level-sensitive, they are seen at the next IDLE.
- Reset asserted mid-pulse:
  - `dout` returns to 1 immediately (asynchronously).
  - `gnt` and `done` clear and the FSM goes to IDLE.
  - No `done` is issued for the interrupted pulse.
- Counter width is LEN_W. It never wraps, because L ≤ 2^LEN_W-1.
- All outputs are registered.

## Timing
- Request sampled at edge t in IDLE → `dout`=0 and `gnt` high from cycle t+1 through t+L.
- `done` and `dout`=1 occur in cycle t+L+1.
- Back-to-back requests: the high time between two pulses is GAP+1 cycles (GAP cycles plus the IDLE arbitration cycle).
- Minimum request-to-request period is L+GAP+1 cycles.
- Round-robin fairness: with all `req` held high, every requester is granted once within N_REQ consecutive pulses.
- If `req` rises in the same cycle that the FSM enters IDLE, it is arbitrated in that cycle.

## Test plan
- Single request: `req`=0001, `len[0]`=3, GAP=1.
  - `dout` low for 3 cycles starting 1 cycle after the sample, with `gnt`=0001.
  - `done`=0001 in cycle 4.
  - `busy` falls 1 cycle later.
- Contention: `req`=1011 held through every `done`, all lengths=2.
  - Grant order is 0,1,3,0,1,3.
  - Between consecutive pulses `dout` is high for exactly 2 cycles (GAP=1).
- Length edge cases:
  - `len`=0 → 1-cycle low pulse.
  - `len`=15 (LEN_W=4) → exactly 15 low cycles, with no wrap.
- Mid-pulse changes: change `len[0]` from 5 to 2 and drop `req[0]` at pulse cycle 2.
  - The pulse still lasts 5 cycles.
  - `done[0]` still asserts.
  - No re-grant follows while `req`=0.
- Reset mid-pulse: assert `rst_n`=0 at pulse cycle 2 of 6.
  - `dout`=1 and `gnt`=0 asynchronously, with no `done`.
  - After release with `req`=0100, the first grant goes to requester 2 (pointer reset to 0).
- GAP=0 with `req`=0011 held: pulses alternate 0,1 with exactly 1 high cycle between them.

Source files
------------

// File: rtl/pulse_sched.sv
// pulse_sched
// Round-robin scheduler sharing one active-low one-shot pulse generator among
// N_REQ requesters. The winner of each arbitration gets a low pulse of its own
// programmable length on dout, a one-cycle done strobe afterwards, and then a
// fixed high gap is enforced before the next arbitration.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   req   - level request per requester, held until the matching done
//   len   - packed pulse lengths, requester i uses [i*LEN_W +: LEN_W]
//   dout  - shared active-low pulse output, idles high
//   gnt   - one-hot grant, high while dout is low for that requester
//   done  - one-cycle completion strobe to the granted requester
//   busy  - high while in PULSE or GAP
module pulse_sched #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 4,
  parameter int GAP   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  output logic                   dout,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy
);

  localparam int               IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0]       GAP_V   = 4'(GAP);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] win_r;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] len_r;
  logic [3:0]       gap_r;

  logic             hit_s;
  logic [IDX_W-1:0] pick_s;
  logic [LEN_W-1:0] pick_len_s;
  logic [LEN_W-1:0] eff_len_s;

  // Index base+off, wrapping modulo N_REQ (off is always < N_REQ).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int off);
    int sum;
    sum = int'(base) + off;
    return IDX_W'((sum >= N_REQ) ? (sum - N_REQ) : sum);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first set request at or above the pointer, wrapping.
  always_comb begin
    hit_s  = 1'b0;
    pick_s = ptr_r;
    for (int i = 0; i < N_REQ; i++) begin
      if (!hit_s && req[wrap_add(ptr_r, i)]) begin
        hit_s  = 1'b1;
        pick_s = wrap_add(ptr_r, i);
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // Winner's length; a zero length still yields a one-cycle pulse.
  always_comb begin
    pick_len_s = len[int'(pick_s)*LEN_W +: LEN_W];
    eff_len_s  = (pick_len_s == '0) ? LEN_ONE : pick_len_s;
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      ptr_r   <= '0;
      win_r   <= '0;
      cnt_r   <= '0;
      len_r   <= '0;
      gap_r   <= 4'd0;
      dout    <= 1'b1;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      done <= '0;
      case (state_r)
        S_IDLE: begin
          dout <= 1'b1;
          gnt  <= '0;
          busy <= 1'b0;
          if (hit_s) begin
            state_r <= S_PULSE;
            win_r   <= pick_s;
            ptr_r   <= wrap_add(pick_s, 32'd1);
            len_r   <= eff_len_s;
            cnt_r   <= LEN_ONE;
            dout    <= 1'b0;
            gnt     <= onehot(pick_s);
            busy    <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_PULSE: begin
          // Requests and len are ignored here: a pulse always runs to length.
          if (cnt_r == len_r) begin
            dout <= 1'b1;
            gnt  <= '0;
            done <= onehot(win_r);
            if (GAP_V != 4'd0) begin
              state_r <= S_GAP;
              gap_r   <= 4'd1;
              busy    <= 1'b1;
            end else begin
              state_r <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + LEN_ONE;
          end
        end
        S_GAP: begin
          if (gap_r == GAP_V) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            gap_r <= gap_r + 4'd1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          dout    <= 1'b1;
          gnt     <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_sched.sv
module tb_pulse_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, req0;
  logic [15:0] len, len0;
  logic        dout, dout0, busy, busy0;
  logic [3:0]  gnt, gnt0, done, done0;

  always #5 clk = ~clk;

  pulse_sched #(.N_REQ(4), .LEN_W(4), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len(len),
    .dout(dout), .gnt(gnt), .done(done), .busy(busy));

  pulse_sched #(.N_REQ(4), .LEN_W(4), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .len(len0),
    .dout(dout0), .gnt(gnt0), .done(done0), .busy(busy0));

  logic       use0;
  logic       m_dout, m_busy;
  logic [3:0] m_gnt, m_done;
  assign m_dout = use0 ? dout0 : dout;
  assign m_gnt  = use0 ? gnt0  : gnt;
  assign m_done = use0 ? done0 : done;
  assign m_busy = use0 ? busy0 : busy;

  int n_vec = 0;
  int n_miss = 0;
  int exp_q[$];

  int         ph, lo, e;
  logic [3:0] g, d, ge;
  logic       b, gs;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = 4'd0;
    req0  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  // Observe one pulse on the selected DUT: high cycles before it, low length,
  // grant seen, whether grant stayed constant, and done/busy in the cycle after.
  task automatic measure(input int budget, output int pre_high, output int low,
                         output logic [3:0] gv, output logic [3:0] dv,
                         output logic bv, output logic stable);
    pre_high = 0; low = -1; gv = 4'd0; dv = 4'd0; bv = 1'b0; stable = 1'b1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (m_dout === 1'b0) begin
        low = 1;
        gv  = m_gnt;
        break;
      end
      pre_high++;
    end
    if (low < 0) return;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (m_dout === 1'b0) begin
        low++;
        if (m_gnt !== gv) stable = 1'b0;
      end else begin
        dv = m_done;
        bv = m_busy;
        return;
      end
    end
    low = -2;
  endtask

  task automatic pop_exp(output int idx);
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard_empty: got no entry want one");
      idx = 0;
    end else begin
      idx = exp_q.pop_front();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({dout, gnt, done, busy} !== 10'b1_0000_0000_0) begin
      n_miss++;
      $display("FAIL reset_gap1: got %b want %b", {dout, gnt, done, busy}, 10'b1_0000_0000_0);
    end
    n_vec++;
    if ({dout0, gnt0, done0, busy0} !== 10'b1_0000_0000_0) begin
      n_miss++;
      $display("FAIL reset_gap0: got %b want %b", {dout0, gnt0, done0, busy0}, 10'b1_0000_0000_0);
    end
  endtask

  task automatic test_single;
    use0 = 1'b0;
    do_reset();
    len = 16'h0003;
    req = 4'b0001;
    exp_q.push_back(0);
    measure(20, ph, lo, g, d, b, gs);
    pop_exp(e);
    ge = 4'b0001 << e;
    req = 4'b0000;
    n_vec++;
    if (ph !== 0) begin n_miss++; $display("FAIL single_latency: got %0d want 0", ph); end
    n_vec++;
    if (lo !== 3) begin n_miss++; $display("FAIL single_low: got %0d want 3", lo); end
    n_vec++;
    if (g !== ge || !gs) begin n_miss++; $display("FAIL single_gnt: got %b want %b", g, ge); end
    n_vec++;
    if (d !== ge) begin n_miss++; $display("FAIL single_done: got %b want %b", d, ge); end
    n_vec++;
    if (b !== 1'b1) begin n_miss++; $display("FAIL single_busy_gap: got %b want 1", b); end
    tick();
    n_vec++;
    if (busy !== 1'b0 || done !== 4'd0) begin
      n_miss++;
      $display("FAIL single_busy_fall: got busy=%b done=%b want 0 0000", busy, done);
    end
  endtask

  task automatic test_contention;
    use0 = 1'b0;
    do_reset();
    len = 16'h2222;
    req = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    for (int p = 0; p < 6; p++) begin
      measure(30, ph, lo, g, d, b, gs);
      if (p == 5) req = 4'b0000;
      pop_exp(e);
      ge = 4'b0001 << e;
      n_vec++;
      if (g !== ge || !gs) begin n_miss++; $display("FAIL contention_gnt%0d: got %b want %b", p, g, ge); end
      n_vec++;
      if (lo !== 2 || d !== ge) begin
        n_miss++;
        $display("FAIL contention_pulse%0d: got low=%0d done=%b want 2 %b", p, lo, d, ge);
      end
      if (p > 0) begin
        n_vec++;
        if (ph + 1 !== 2) begin n_miss++; $display("FAIL contention_high%0d: got %0d want 2", p, ph + 1); end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_len_edges;
    use0 = 1'b0;
    do_reset();
    len = 16'h0000;
    req = 4'b0001;
    exp_q.push_back(0);
    measure(20, ph, lo, g, d, b, gs);
    req = 4'b0000;
    pop_exp(e);
    ge = 4'b0001 << e;
    n_vec++;
    if (lo !== 1 || g !== ge || d !== ge) begin
      n_miss++;
      $display("FAIL len_zero: got low=%0d gnt=%b done=%b want 1 %b %b", lo, g, d, ge, ge);
    end
    repeat (3) tick();
    len = 16'h000F;
    req = 4'b0001;
    exp_q.push_back(0);
    measure(40, ph, lo, g, d, b, gs);
    req = 4'b0000;
    pop_exp(e);
    ge = 4'b0001 << e;
    n_vec++;
    if (lo !== 15 || !gs || d !== ge) begin
      n_miss++;
      $display("FAIL len_max: got low=%0d stable=%b done=%b want 15 1 %b", lo, gs, d, ge);
    end
    repeat (3) tick();
  endtask

  task automatic test_mid_pulse;
    int stray;
    use0 = 1'b0;
    do_reset();
    len = 16'h0005;
    req = 4'b0001;
    exp_q.push_back(0);
    lo = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (dout === 1'b0) begin lo = 1; g = gnt; break; end
    end
    tick();
    if (dout === 1'b0) lo++;
    len = 16'h0002;
    req = 4'b0000;
    d = 4'd0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (dout === 1'b0) lo++;
      else begin d = done; break; end
    end
    pop_exp(e);
    ge = 4'b0001 << e;
    n_vec++;
    if (lo !== 5 || g !== ge) begin
      n_miss++;
      $display("FAIL mid_len: got low=%0d gnt=%b want 5 %b", lo, g, ge);
    end
    n_vec++;
    if (d !== ge) begin n_miss++; $display("FAIL mid_done: got %b want %b", d, ge); end
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (dout !== 1'b1 || gnt !== 4'd0) stray++;
    end
    n_vec++;
    if (stray !== 0) begin n_miss++; $display("FAIL mid_regrant: got %0d low cycles want 0", stray); end
  endtask

  task automatic test_reset_mid;
    int seen_done;
    use0 = 1'b0;
    do_reset();
    len = 16'h0006;
    req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (dout === 1'b0) break;
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({dout, gnt, done} !== 9'b1_0000_0000) begin
      n_miss++;
      $display("FAIL rstmid_async: got %b want %b", {dout, gnt, done}, 9'b1_0000_0000);
    end
    req = 4'b0100;
    len = 16'h0300;
    seen_done = 0;
    repeat (2) begin
      tick();
      if (done !== 4'd0 || dout !== 1'b1) seen_done++;
    end
    rst_n = 1'b1;
    exp_q.push_back(2);
    measure(20, ph, lo, g, d, b, gs);
    req = 4'b0000;
    pop_exp(e);
    ge = 4'b0001 << e;
    n_vec++;
    if (seen_done !== 0) begin n_miss++; $display("FAIL rstmid_hold: got %0d bad cycles want 0", seen_done); end
    n_vec++;
    if (g !== ge || lo !== 3 || d !== ge) begin
      n_miss++;
      $display("FAIL rstmid_regrant: got gnt=%b low=%0d done=%b want %b 3 %b", g, lo, d, ge, ge);
    end
    repeat (3) tick();
  endtask

  task automatic test_gap0;
    use0 = 1'b1;
    do_reset();
    len0 = 16'h2222;
    req0 = 4'b0011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    for (int p = 0; p < 4; p++) begin
      measure(30, ph, lo, g, d, b, gs);
      if (p == 3) req0 = 4'b0000;
      pop_exp(e);
      ge = 4'b0001 << e;
      n_vec++;
      if (g !== ge || lo !== 2 || d !== ge) begin
        n_miss++;
        $display("FAIL gap0_pulse%0d: got gnt=%b low=%0d done=%b want %b 2 %b", p, g, lo, d, ge, ge);
      end
      if (p > 0) begin
        n_vec++;
        if (ph + 1 !== 1) begin n_miss++; $display("FAIL gap0_high%0d: got %0d want 1", p, ph + 1); end
      end
    end
    n_vec++;
    if (b !== 1'b0) begin n_miss++; $display("FAIL gap0_busy: got %b want 0", b); end
    use0 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'd0;
    req0  = 4'd0;
    len   = 16'd0;
    len0  = 16'd0;
    use0  = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_len_edges();
    test_mid_pulse();
    test_reset_mid();
    test_gap0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
